// File: rtl/chronos_mem_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// access-size decode and byte-lane mask/data generation.
package chronos_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} mau_state_e;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

   // Request fields captured at acceptance and held through WAIT.
   typedef struct packed {
      logic        write;
      acc_size_e   size;
      logic        is_unsigned;
      logic [1:0]  off;
      logic [29:0] waddr;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } mem_req_t;

   // Loads and stores decode funct3 differently; unused codes fall back to word.
   function automatic acc_size_e decode_size(input logic write, input logic [2:0] funct3);
      acc_size_e sz;
      if (write) begin
         if (funct3 == F3_SB)      sz = SZ_BYTE;
         else if (funct3 == F3_SH) sz = SZ_HALF;
         else                      sz = SZ_WORD;
      end else begin
         case (funct3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
   endfunction

   function automatic logic [3:0] lane_mask(input acc_size_e size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = 4'b0011 << {off[1], 1'b0};
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_data(input acc_size_e size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it to 32 bits.
module lsu_load_align
   import chronos_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  byte_off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (byte_off)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = rdata;
      if (size == SZ_BYTE)
         data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      else if (size == SZ_HALF)
         data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: stalls the pipeline while one word-bus access is
// outstanding, formats load data, flags misaligned accesses and bus timeouts.
module mem_access_unit
   import chronos_mem_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_error,
   output logic        mem_enable,
   output logic        mem_cmd,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_mask,
   output logic [31:0] mem_wdata,
   input  logic        mem_valid,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   mau_state_e       state, nxt;
   mem_req_t         lat;
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;
   acc_size_e        req_size;
   logic             req_mis, req_hit, accept, timeout;
   logic [31:0]      aligned_data;

   assign req_size = decode_size(req_write, req_funct3);
   assign req_mis  = is_misaligned(req_size, req_addr[1:0]);
   assign req_hit  = rst && (state == ST_IDLE) && req_valid;
   assign accept   = req_hit && !req_mis;
   assign timeout  = (state == ST_WAIT) && !mem_valid && (wait_cnt == CNT_W'(MAX_WAIT - 1));

   lsu_load_align u_align (
      .rdata       (mem_rdata),
      .byte_off    (lat.off),
      .size        (lat.size),
      .is_unsigned (lat.is_unsigned),
      .data        (aligned_data)
   );

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: if (accept) nxt = ST_WAIT;
         ST_WAIT: if (mem_valid || timeout) nxt = ST_DONE;
         ST_DONE: nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         lat       <= '0;
         wait_cnt  <= '0;
         err_q     <= 1'b0;
         load_data <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            lat <= '{write:       req_write,
                     size:        req_size,
                     is_unsigned: req_funct3[2],
                     off:         req_addr[1:0],
                     waddr:       req_addr[31:2],
                     mask:        lane_mask(req_size, req_addr[1:0]),
                     wdata:       store_data(req_size, req_wdata)};
            wait_cnt <= '0;
            err_q    <= 1'b0;
         end
         if (state == ST_WAIT) begin
            if (mem_valid) begin
               if (!lat.write) load_data <= aligned_data;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
               if (timeout) begin
                  err_q     <= 1'b1;
                  load_data <= '0;
               end
            end
         end
      end
   end

   // Combinational strobes are gated by reset so nothing leaks while rst is low.
   assign stall      = accept || (rst && (state == ST_WAIT));
   assign misaligned = req_hit && req_mis;
   assign resp_valid = rst && (state == ST_DONE);
   assign bus_error  = rst && (state == ST_DONE) && err_q;
   assign mem_enable = rst && (state == ST_WAIT);
   assign mem_cmd    = lat.write;
   assign mem_addr   = {lat.waddr, 2'b00};
   assign mem_mask   = lat.mask;
   assign mem_wdata  = lat.wdata;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, the number of WAIT cycles without mem_valid before a bus error is declared.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  EX/MEM holds a load or store.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width/sign field.
REQ-008 req_addr  in  32  byte address (EX/MEM ALU result).
REQ-009 req_wdata  in  32  store data (rs2 value).
REQ-010 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 load_data  out  32  aligned, extended load result to writeback.
REQ-013 misaligned  out  1  one-cycle misaligned-access pulse.
REQ-014 bus_error  out  1  one-cycle timeout pulse.
REQ-015 mem_enable, mem_cmd  out  1 each  memory request level and write flag.
REQ-016 mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00}).
REQ-017 mem_mask  out  4  byte-lane enables.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_valid  in  1, mem_rdata  in  32  memory response.

Function
REQ-020 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-021 IDLE: if req_valid and aligned, SHALL latch funct3, addr[1:0], write, mask and wdata, and go to WAIT.
REQ-022 stall SHALL be 1 in WAIT, and 1 combinationally in IDLE when an aligned req_valid is accepted; it SHALL be 0 otherwise.
REQ-023 mem_enable SHALL be 1 throughout WAIT only; mem_cmd, mem_addr, mem_mask and mem_wdata SHALL be driven from the latched values and be stable through WAIT.
REQ-024 mem_valid SHALL be sampled only in WAIT; it SHALL be ignored in IDLE and DONE.
REQ-025 WAIT with mem_valid=1: SHALL register the formatted load_data (stores: unchanged) and go to DONE.
REQ-026 DONE: resp_valid=1 and stall=0; SHALL return unconditionally to IDLE, ignoring the still-present req_valid (no re-issue).
REQ-027 Minimum latency SHALL be accept -> WAIT -> DONE, i.e. resp_valid two cycles after acceptance.
REQ-028 Wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_valid.
REQ-029 When the wait count reaches MAX_WAIT: bus_error=1, load_data=0, mem_enable drops, and the FSM goes to DONE (resp_valid also pulses).
REQ-030 Alignment: halfword access with addr[0]=1, or word access with addr[1:0]!=0, SHALL be misaligned.
REQ-031 Misaligned access SHALL pulse misaligned for one cycle, SHALL NOT issue a memory request, resp_valid and stall SHALL stay 0, and the FSM SHALL remain in IDLE.
REQ-032 Byte mask SHALL be 4'b0001<<addr[1:0]; halfword mask SHALL be 4'b0011<<{addr[1],1'b0}; word mask SHALL be 4'b1111. Loads use the same masks.
REQ-033 Store data: SB SHALL drive {4{wdata[7:0]}}; SH SHALL drive {2{wdata[15:0]}}; SW SHALL pass wdata.
REQ-034 Load format: select the lane by addr[1:0]; LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass mem_rdata.
REQ-035 Unused funct3 codes (load 011/110/111, store >=011) SHALL be treated as word accesses.

Reset
REQ-036 When rst=0 at a clock edge: state SHALL become IDLE, the counter 0, and load_data 0.
REQ-037 During reset, stall, resp_valid, misaligned, bus_error, mem_enable, mem_cmd and mem_mask SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-038 Reset mid-WAIT SHALL abandon the request with no response pulse; reset SHALL win over a simultaneous mem_valid.

Structure
REQ-039 Shared package chronos_mem_pkg SHALL hold the funct3 constants (LB..LHU, SB..SW) and the FSM state enum.
REQ-040 Load lane extraction/extension SHALL be a combinational sub-module, lsu_load_align.

Verification
REQ-041 LW 0x100, mem_valid on the 1st WAIT cycle, rdata 0xDEADBEEF -> mask 1111; resp_valid two cycles after accept; load_data 0xDEADBEEF; stall high for 2 cycles.
REQ-042 LB 0x103, rdata 0x80xxxxxx -> mask 1000, load_data 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-043 SH 0x102, wdata 0x1234ABCD -> mem_cmd=1, mask 1100, mem_wdata 0xABCDABCD, mem_addr 0x100.
REQ-044 LW 0x101 -> misaligned pulses once, mem_enable never 1, stall 0, no resp_valid.
REQ-045 LW with mem_valid held 0 and MAX_WAIT=4 -> bus_error and resp_valid after 4 WAIT cycles, load_data 0.
REQ-046 rst=0 in the 2nd WAIT cycle with mem_valid=1 -> next cycle IDLE, all outputs 0, no resp_valid.
